scores_table_reader: RTL

// Parametrised successor of the single-score reader. On request, fetches NUM_ENTRIES score words

---
 rtl/scores_table_reader.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/scores_table_reader.sv
`default_nettype none
// ============================================================================
// Module      : scores_table_reader
// Description : Scans NUM_ENTRIES score words from consecutive SD addresses
//               through the SD read handshake, keeps them in a local table and
//               tracks the best (largest unsigned) score and its index.
//               Requests that the SD controller never answers are re-issued
//               after a short backoff; a stalled scan ends in an error state.
// Revision    : 1.0 - initial release
// ============================================================================
module scores_table_reader #(
    parameter int          DATA_W         = 16,
    parameter int          NUM_ENTRIES    = 8,
    parameter logic [31:0] BASE_ADDRESS   = 32'd0,
    parameter logic [31:0] ADDR_STRIDE    = 32'd1,
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter int          MAX_RETRY      = 3,
    localparam int         IDX_W          = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              TO_GET,
    input  logic              SD_HAS_INITIALIZED,
    input  logic              SD_IS_READING,
    input  logic [DATA_W-1:0] READ_DATA,
    output logic              SD_TO_READ,
    output logic [31:0]       SD_READ_ADDRESS,
    output logic              READ_FINISH,
    output logic              READ_ERROR,
    output logic [IDX_W:0]    ENTRIES_VALID,
    input  logic [IDX_W-1:0]  ENTRY_SEL,
    output logic [DATA_W-1:0] ENTRY_SCORE,
    output logic [DATA_W-1:0] BEST_SCORE,
    output logic [IDX_W-1:0]  BEST_INDEX
);

    localparam int TIMER_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int RETRY_W     = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    // Table is rounded up to a power of two so any ENTRY_SEL value indexes
    // a real word; words at or beyond NUM_ENTRIES are never written.
    localparam int TABLE_DEPTH = 1 << IDX_W;

    localparam logic [IDX_W-1:0]   LAST_IDX    = IDX_W'(NUM_ENTRIES - 1);
    localparam logic [IDX_W:0]     ENTRY_COUNT = (IDX_W + 1)'(NUM_ENTRIES);
    localparam logic [TIMER_W-1:0] TIMER_LAST  = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_REQUEST   = 3'd1,
        S_BACKOFF   = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_STORE     = 3'd4,
        S_DONE      = 3'd5,
        S_ERROR     = 3'd6
    } state_t;

    state_t               state;
    logic [IDX_W-1:0]     idx;
    logic [RETRY_W-1:0]   retry;
    logic [TIMER_W-1:0]   timer;
    logic                 to_get_q;
    logic [DATA_W-1:0]    score_table [TABLE_DEPTH];

    logic                 start_ok;
    logic                 launch;
    logic                 sel_in_range;

    // A scan may only start while the controller is up and idle. From IDLE
    // TO_GET acts as a level; from DONE/ERROR only a fresh rising edge
    // restarts, so a requester holding TO_GET high does not loop forever.
    assign start_ok = SD_HAS_INITIALIZED & ~SD_IS_READING;
    assign launch   = start_ok & TO_GET &
                      ((state == S_IDLE) |
                       (((state == S_DONE) | (state == S_ERROR)) & ~to_get_q));

    // Address follows idx, which only changes on the STORE exit edge
    assign SD_READ_ADDRESS = BASE_ADDRESS + (32'(idx) * ADDR_STRIDE);

    assign sel_in_range = ({1'b0, ENTRY_SEL} < ENTRY_COUNT);
    assign ENTRY_SCORE  = sel_in_range ? score_table[ENTRY_SEL] : '0;

    // Scan sequencer: request, wait for the read, store, advance
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state         <= S_IDLE;
            idx           <= '0;
            retry         <= '0;
            timer         <= '0;
            to_get_q      <= 1'b0;
            SD_TO_READ    <= 1'b0;
            READ_FINISH   <= 1'b0;
            READ_ERROR    <= 1'b0;
            ENTRIES_VALID <= '0;
            BEST_SCORE    <= '0;
            BEST_INDEX    <= '0;
            for (int i = 0; i < TABLE_DEPTH; i++) begin
                score_table[i] <= '0;
            end
        end else begin
            to_get_q <= TO_GET;
            if (launch) begin
                // Table words are kept; only the bookkeeping restarts
                state         <= S_REQUEST;
                SD_TO_READ    <= 1'b1;
                READ_FINISH   <= 1'b0;
                READ_ERROR    <= 1'b0;
                idx           <= '0;
                retry         <= '0;
                timer         <= '0;
                ENTRIES_VALID <= '0;
                BEST_SCORE    <= '0;
                BEST_INDEX    <= '0;
            end else begin
                case (state)
                    S_REQUEST: begin
                        if (SD_IS_READING) begin
                            state      <= S_WAIT_DONE;
                            SD_TO_READ <= 1'b0;
                            timer      <= '0;
                        end else if (timer == TIMER_LAST) begin
                            SD_TO_READ <= 1'b0;
                            timer      <= '0;
                            if (retry < RETRY_LIMIT) begin
                                retry <= retry + 1'b1;
                                state <= S_BACKOFF;
                            end else begin
                                READ_ERROR <= 1'b1;
                                state      <= S_ERROR;
                            end
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    S_BACKOFF: begin
                        // One idle cycle so the controller sees a fresh request edge
                        timer      <= '0;
                        SD_TO_READ <= 1'b1;
                        state      <= S_REQUEST;
                    end
                    S_WAIT_DONE: begin
                        // An in-flight read is never re-issued; a stall is fatal
                        if (!SD_IS_READING) begin
                            state <= S_STORE;
                        end else if (timer == TIMER_LAST) begin
                            timer      <= '0;
                            READ_ERROR <= 1'b1;
                            state      <= S_ERROR;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    S_STORE: begin
                        score_table[idx] <= READ_DATA;
                        ENTRIES_VALID    <= ENTRIES_VALID + 1'b1;
                        // Strict compare keeps the lowest index on ties
                        if ((READ_DATA > BEST_SCORE) || (idx == '0)) begin
                            BEST_SCORE <= READ_DATA;
                            BEST_INDEX <= idx;
                        end
                        if (idx == LAST_IDX) begin
                            READ_FINISH <= 1'b1;
                            state       <= S_DONE;
                        end else begin
                            idx        <= idx + 1'b1;
                            retry      <= '0;
                            timer      <= '0;
                            SD_TO_READ <= 1'b1;
                            state      <= S_REQUEST;
                        end
                    end
                    S_IDLE, S_DONE, S_ERROR: begin
                    end
                    default: begin
                        SD_TO_READ <= 1'b0;
                        state      <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire
